// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC custom-instruction controller.
//   - WIDTH      : fractional bits of the internal Q2.WIDTH fixed-point words.
//   - fixed_t    : signed WIDTH+2 bit datapath word.
//   - ONE_Q/K_Q  : +1.0 and the CORDIC gain compensation constant.
//   - ATAN_TAB   : round(atan(2^-i) * 2^WIDTH) for i = 0..WIDTH-1.
//   - state_t    : controller FSM states.
//   The arctangent table is hand-tabulated for WIDTH = 24, so WIDTH lives
//   here rather than as a module parameter.
package cordic_pkg;

  localparam int WIDTH              = 24;
  localparam int ITERATIONS_DEFAULT = 22;
  localparam int IW                 = $clog2(WIDTH);

  typedef logic signed [WIDTH+1:0] fixed_t;

  localparam fixed_t ONE_Q = fixed_t'(16777216);  // 1.0 in Q2.24
  localparam fixed_t K_Q   = fixed_t'(10188014);  // 0.6072529350 * 2^24

  localparam fixed_t ATAN_TAB [0:WIDTH-1] = '{
    fixed_t'(13176795), fixed_t'(7778716),  fixed_t'(4110060),  fixed_t'(2086331),
    fixed_t'(1047214),  fixed_t'(524117),   fixed_t'(262123),   fixed_t'(131069),
    fixed_t'(65536),    fixed_t'(32768),    fixed_t'(16384),    fixed_t'(8192),
    fixed_t'(4096),     fixed_t'(2048),     fixed_t'(1024),     fixed_t'(512),
    fixed_t'(256),      fixed_t'(128),      fixed_t'(64),       fixed_t'(32),
    fixed_t'(16),       fixed_t'(8),        fixed_t'(4),        fixed_t'(2)
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    PACK = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_iter_stage.sv
// cordic_iter_stage
//   One combinational rotation-mode CORDIC micro-rotation.
//   Ports:
//     x, y, z           : current vector and residual angle (Q2.WIDTH)
//     i                 : iteration index, used as shift amount and table index
//     x_next, y_next,
//     z_next            : vector and residual angle after this micro-rotation
module cordic_iter_stage
  import cordic_pkg::*;
(
  input  fixed_t          x,
  input  fixed_t          y,
  input  fixed_t          z,
  input  logic [IW-1:0]   i,
  output fixed_t          x_next,
  output fixed_t          y_next,
  output fixed_t          z_next
);

  fixed_t x_sh;
  fixed_t y_sh;
  fixed_t ang;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    ang  = ATAN_TAB[i];
    // Rotate toward zero residual angle: d = +1 while z is non-negative.
    if (!z[WIDTH+1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - ang;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + ang;
    end
  end

endmodule

// File: rtl/cordic_packer.sv
// cordic_packer
//   Combinational Q2.WIDTH -> float32 conversion.
//   Ports:
//     q : signed fixed-point input
//     f : IEEE-754 single-precision result (mantissa truncated)
//   Zero packs to +0.0; negative inputs pack as sign-magnitude.
module cordic_packer
  import cordic_pkg::*;
(
  input  fixed_t      q,
  output logic [31:0] f
);

  logic             neg;
  logic [WIDTH+1:0] mag;
  logic [22:0]      mant;
  int               p;

  always_comb begin
    neg = q[WIDTH+1];
    mag = neg ? -q : q;
    // Position of the leading one; the highest set bit wins.
    p = 0;
    for (int b = 0; b < WIDTH + 2; b++) begin
      if (mag[b]) p = b;
    end
    // Normalise the leading one to bit 63, then bits 62:40 are the fraction.
    mant = 23'((64'(mag) << (63 - p)) >> 40);
    f    = '0;
    if (mag != '0) begin
      f = {neg, 8'(127 + p - WIDTH), mant};
    end
  end

endmodule

// File: rtl/cordic_unpacker.sv
// cordic_unpacker
//   Combinational float32 -> Q2.WIDTH conversion with saturation to +/-1.0.
//   Ports:
//     f : IEEE-754 single-precision input (radians)
//     q : signed fixed-point result, clamped to [-ONE_Q, +ONE_Q]
//   Zeros and denormals map to 0; |f| >= 1.0, Inf and NaN saturate to 1.0
//   with the input sign. Bits below 2^-WIDTH are truncated.
module cordic_unpacker
  import cordic_pkg::*;
(
  input  logic [31:0] f,
  output fixed_t      q
);

  logic [7:0]       e;
  logic [23:0]      m;
  logic [WIDTH+1:0] mag;
  int               amt;

  always_comb begin
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    mag = '0;
    amt = 0;
    if (e == 8'd0) begin
      mag = '0;
    end else if (e >= 8'd127) begin
      mag = ONE_Q;
    end else begin
      // The mantissa is parked 40 bits up so the shift is always rightward:
      // fixed = m * 2^(e - 150 + WIDTH) = (m << 40) >> (190 - WIDTH - e).
      amt = 190 - WIDTH - int'(e);
      mag = (WIDTH+2)'({m, 40'd0} >> amt);
    end
    q = f[31] ? -fixed_t'(mag) : fixed_t'(mag);
  end

endmodule

// File: rtl/cordic_ctrl.sv
// cordic_ctrl
//   Multicycle custom-instruction controller computing cos/sin of a float32
//   angle: unpack (LOAD), ITERATIONS micro-rotations (ITER), pack (PACK).
//   Ports:
//     clk     : system clock
//     reset   : asynchronous active-high reset, aborts any operation
//     clk_en  : clock enable; low freezes every register including done
//     start   : request pulse, accepted only in IDLE outside the done cycle
//     n       : function select latched at start (0 = cos, 1 = sin)
//     dataa   : float32 angle in radians, latched at start
//     done    : completion pulse (stretched while clk_en is low)
//     result  : float32 result, held from done until the next done
//   ITERATIONS must lie in 1..WIDTH.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = ITERATIONS_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  state_t        state_reg;
  state_t        state_next;
  fixed_t        x_reg;
  fixed_t        y_reg;
  fixed_t        z_reg;
  logic [IW-1:0] i_reg;
  logic          n_reg;
  logic [31:0]   dataa_reg;
  logic          done_reg;
  logic [31:0]   result_reg;

  fixed_t        z_load;
  fixed_t        x_step;
  fixed_t        y_step;
  fixed_t        z_step;
  fixed_t        pack_in;
  logic [31:0]   packed_val;
  logic          accept;
  logic          last_iter;

  // done_reg is high exactly in the IDLE cycle that follows PACK, so gating
  // on it drops a start that coincides with the completion pulse.
  assign accept    = (state_reg == IDLE) && start && !done_reg;
  assign last_iter = (i_reg == IW'(ITERATIONS - 1));
  assign pack_in   = n_reg ? y_reg : x_reg;

  cordic_unpacker u_unpack (
    .f (dataa_reg),
    .q (z_load)
  );

  cordic_iter_stage u_iter (
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .i      (i_reg),
    .x_next (x_step),
    .y_next (y_step),
    .z_next (z_step)
  );

  cordic_packer u_pack (
    .q (pack_in),
    .f (packed_val)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = ITER;
      ITER:    if (last_iter) state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      i_reg      <= '0;
      n_reg      <= 1'b0;
      dataa_reg  <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (clk_en) begin
      state_reg <= state_next;
      done_reg  <= (state_reg == PACK);
      if (accept) begin
        n_reg     <= n;
        dataa_reg <= dataa;
      end
      case (state_reg)
        LOAD: begin
          x_reg <= K_Q;
          y_reg <= '0;
          z_reg <= z_load;
          i_reg <= '0;
        end
        ITER: begin
          x_reg <= x_step;
          y_reg <= y_step;
          z_reg <= z_step;
          i_reg <= i_reg + 1'b1;
        end
        PACK: result_reg <= packed_val;
        default: ;
      endcase
    end
  end

  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb_cordic_ctrl
//   Directed bench for cordic_ctrl: reset state, cos/sin values against
//   true trigonometric values, latency, clamping, stall, abort and
//   back-to-back requests.
module tb_cordic_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic        n;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int lat;
  int highs;

  localparam real TOL = 1.0 / 1048576.0;  // 2^-20

  localparam real COS_0    = 1.0;
  localparam real SIN_HALF = 0.479425538604203;
  localparam real COS_HALF = 0.8775825618903728;
  localparam real SIN_M1   = -0.8414709848078965;
  localparam real COS_1    = 0.5403023058681398;

  cordic_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int k = 127; k < e; k++) v = v * 2.0;
    for (int k = e; k < 127; k++) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input real want);
    real  err;
    logic ok;
    err = f2r(got) - want;
    if (err < 0.0) err = -err;
    ok = (err <= TOL);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %h (%f), expected %f within 2^-20", tag, got, f2r(got), want);
    end
  endtask

  // Counts edges from the one that sampled start (base = edges already seen);
  // returns the latency in cycles including the start cycle, or -1 on timeout.
  task automatic wait_done(input int base, output int l);
    int c;
    bit seen;
    c    = base;
    seen = 1'b0;
    while (!seen && c < base + 100) begin
      tick();
      c++;
      if (done === 1'b1) seen = 1'b1;
    end
    l = seen ? c + 1 : -1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic nsel, output int l);
    dataa = a;
    n     = nsel;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, l);
  endtask

  task automatic count_done(input int cycles, output int h);
    h = 0;
    repeat (cycles) begin
      tick();
      if (done === 1'b1) h++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = 1'b0;
    dataa  = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'h0);
    $display("[TB] reset: done=%b result=%h", done, result);

    // cos(0), then stretch the done pulse with clk_en low
    run_op(32'h00000000, 1'b0, lat);
    check_int("lat_cos0", lat, 25);
    check_val("cos0", result, COS_0);
    $display("[TB] cos(0.0)  -> %h latency %0d", result, lat);
    clk_en = 1'b0;
    repeat (3) tick();
    check_eq("done_stretch", 32'(done), 32'd1);
    clk_en = 1'b1;
    tick();
    check_eq("done_drop", 32'(done), 32'd0);

    // sin/cos(0.5)
    run_op(32'h3f000000, 1'b1, lat);
    check_val("sin_half", result, SIN_HALF);
    $display("[TB] sin(0.5)  -> %h latency %0d", result, lat);
    tick();
    run_op(32'h3f000000, 1'b0, lat);
    check_val("cos_half", result, COS_HALF);
    check_int("lat_cos_half", lat, 25);
    $display("[TB] cos(0.5)  -> %h latency %0d", result, lat);
    tick();

    // sin(-1.0) and clamped cos(2.0)
    run_op(32'hbf800000, 1'b1, lat);
    check_val("sin_m1", result, SIN_M1);
    check_eq("sin_m1_sign", 32'(result[31]), 32'd1);
    $display("[TB] sin(-1.0) -> %h latency %0d", result, lat);
    tick();
    run_op(32'h40000000, 1'b0, lat);
    check_val("cos_2_clamped", result, COS_1);
    $display("[TB] cos(2.0)  -> %h latency %0d", result, lat);
    tick();

    // Re-pulsed start during ITER (with changed inputs) plus a 5-cycle stall
    dataa = 32'h3f000000;
    n     = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    dataa = 32'h00000000;
    n     = 1'b0;
    start = 1'b1;
    tick();
    start  = 1'b0;
    clk_en = 1'b0;
    repeat (5) tick();
    clk_en = 1'b1;
    wait_done(11, lat);
    check_int("lat_stall", lat, 30);
    check_val("sin_half_stall", result, SIN_HALF);
    $display("[TB] stalled sin(0.5) -> %h latency %0d", result, lat);
    count_done(40, highs);
    check_int("no_extra_done", highs, 0);

    // Reset in the middle of ITER
    dataa = 32'h3f000000;
    n     = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    #1;
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", result, 32'h0);
    $display("[TB] abort: done=%b result=%h", done, result);
    tick();
    reset = 1'b0;
    count_done(40, highs);
    check_int("abort_no_done", highs, 0);
    run_op(32'h3f000000, 1'b0, lat);
    check_int("lat_after_abort", lat, 25);
    check_val("cos_half_after_abort", result, COS_HALF);
    $display("[TB] post-abort cos(0.5) -> %h latency %0d", result, lat);

    // Back-to-back: start held through the done cycle (ignored there) and
    // accepted on the following cycle with a different angle.
    dataa = 32'hbf800000;
    n     = 1'b1;
    start = 1'b1;
    tick();
    check_val("hold_first", result, COS_HALF);
    tick();
    start = 1'b0;
    repeat (10) tick();
    check_val("hold_mid", result, COS_HALF);
    wait_done(10, lat);
    check_int("lat_b2b", lat, 25);
    check_val("sin_m1_b2b", result, SIN_M1);
    $display("[TB] back-to-back sin(-1.0) -> %h latency %0d", result, lat);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
